// File: rtl/sync_ptr_multi.sv
// Multi-channel gray pointer synchroniser into the wclk domain with binary decode,
// forward-distance, update pulse and sticky illegal-transition detection per channel.
module sync_ptr_multi #(
    parameter int unsigned ASIZE  = 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CH     = 1
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [CH*(ASIZE+1)-1:0] rptr,
    input  logic                    err_clr,
    output logic [CH*(ASIZE+1)-1:0] rptr_sync,
    output logic [CH*(ASIZE+1)-1:0] rptr_bin,
    output logic [CH*(ASIZE+1)-1:0] rptr_delta,
    output logic [CH-1:0]           rptr_upd,
    output logic [CH-1:0]           gray_err,
    output logic                    sync_valid
);

    localparam int unsigned W         = ASIZE + 1;
    localparam logic [3:0]  VALID_CNT = 4'(STAGES + 1);

    logic [CH*W-1:0] sync_q [STAGES];
    logic [CH*W-1:0] prev_q;
    logic [CH*W-1:0] bin_q,   bin_d;
    logic [CH*W-1:0] delta_q, delta_d;
    logic [CH-1:0]   upd_q,   upd_d;
    logic [CH-1:0]   err_q,   err_d;
    logic [3:0]      cnt_q;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int unsigned i = 1; i < W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    function automatic logic [W-1:0] chan(input logic [CH*W-1:0] v, input int unsigned c);
        return v[c*W +: W];
    endfunction

    // More than one bit set: clearing the lowest set bit leaves something behind.
    function automatic logic multi_bit(input logic [W-1:0] x);
        return (x & (x - W'(1))) != '0;
    endfunction

    always_comb begin
        bin_d   = '0;
        delta_d = '0;
        upd_d   = '0;
        err_d   = err_clr ? '0 : err_q;
        for (int unsigned c = 0; c < CH; c++) begin
            bin_d[c*W +: W] = gray2bin(chan(sync_q[STAGES-1], c));
            if (chan(sync_q[STAGES-1], c) != chan(prev_q, c)) begin
                upd_d[c]          = 1'b1;
                delta_d[c*W +: W] = gray2bin(chan(sync_q[STAGES-1], c))
                                  - gray2bin(chan(prev_q, c));
            end
            if (sync_valid && multi_bit(chan(sync_q[STAGES-1], c) ^ chan(prev_q, c))) begin
                err_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q  <= '0;
            bin_q   <= '0;
            delta_q <= '0;
            upd_q   <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync_q[0] <= rptr;
            for (int unsigned s = 1; s < STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q  <= sync_q[STAGES-1];
            bin_q   <= bin_d;
            delta_q <= delta_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign rptr_sync  = sync_q[STAGES-1];
    assign rptr_bin   = bin_q;
    assign rptr_delta = delta_q;
    assign rptr_upd   = upd_q;
    assign gray_err   = err_q;
    assign sync_valid = (cnt_q >= VALID_CNT);

endmodule
